// File: rtl/seq_tx.sv
// seq_tx: start/ready serial frame transmitter, MSB-first, one zero gap bit per frame.
// Optional 1,0,1 frame preamble enabled by defining SEQ_TX_PREAMBLE_EN.
`default_nettype none

module seq_tx #(
    parameter int WIDTH = 8,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [REP_W-1:0] rep_in,
    input  logic             abort,
    output logic             out_seq,
    output logic             busy,
    output logic             ready,
    output logic             done
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] c_BIT_TOP = BIT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_DATA = 2'd2;
    localparam logic [1:0] c_GAP  = 2'd3;
`ifdef SEQ_TX_PREAMBLE_EN
    localparam logic [1:0] c_PRE  = 2'd1;
    localparam logic [1:0] c_FIRST = c_PRE;
`else
    localparam logic [1:0] c_FIRST = c_DATA;
`endif

    logic [1:0]       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_word, w_word_nxt;
    logic [REP_W-1:0] r_rep, w_rep_nxt;
    logic [BIT_W-1:0] r_bit, w_bit_nxt;
`ifdef SEQ_TX_PREAMBLE_EN
    logic [1:0]       r_pre, w_pre_nxt;
`endif
    logic             r_out, r_busy, r_done;
    logic             w_out_nxt, w_busy_nxt, w_done_nxt;
    logic             w_accept, w_abort;

    assign w_accept = start && !r_busy && !abort;
    assign w_abort  = abort && r_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_word  <= '0;
            r_rep   <= '0;
            r_bit   <= '0;
`ifdef SEQ_TX_PREAMBLE_EN
            r_pre   <= '0;
`endif
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_rep   <= w_rep_nxt;
            r_bit   <= w_bit_nxt;
`ifdef SEQ_TX_PREAMBLE_EN
            r_pre   <= w_pre_nxt;
`endif
            r_out   <= w_out_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_rep_nxt   = r_rep;
        w_bit_nxt   = r_bit;
`ifdef SEQ_TX_PREAMBLE_EN
        w_pre_nxt   = r_pre;
`endif
        if (w_abort) begin
            w_state_nxt = c_IDLE;
            w_rep_nxt   = '0;
            w_bit_nxt   = '0;
`ifdef SEQ_TX_PREAMBLE_EN
            w_pre_nxt   = '0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        w_word_nxt  = data_in;
                        w_rep_nxt   = rep_in;
                        w_bit_nxt   = c_BIT_TOP;
`ifdef SEQ_TX_PREAMBLE_EN
                        w_pre_nxt   = 2'd2;
`endif
                        w_state_nxt = c_FIRST;
                    end
                end
`ifdef SEQ_TX_PREAMBLE_EN
                // Preamble counter runs 2,1,0; its inverted LSB gives the 1,0,1 marker.
                c_PRE: begin
                    if (r_pre == 2'd0) begin
                        w_state_nxt = c_DATA;
                    end else begin
                        w_pre_nxt = r_pre - 2'd1;
                    end
                end
`endif
                c_DATA: begin
                    if (r_bit == '0) begin
                        w_state_nxt = c_GAP;
                    end else begin
                        w_bit_nxt = r_bit - 1'b1;
                    end
                end
                c_GAP: begin
                    if (r_rep != '0) begin
                        w_rep_nxt   = r_rep - 1'b1;
                        w_bit_nxt   = c_BIT_TOP;
`ifdef SEQ_TX_PREAMBLE_EN
                        w_pre_nxt   = 2'd2;
`endif
                        w_state_nxt = c_FIRST;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    // Outputs are derived from the next-state values so the line bit is registered with the state.
    always_comb begin
        w_out_nxt  = 1'b0;
        w_busy_nxt = (w_state_nxt != c_IDLE);
        w_done_nxt = (r_state == c_GAP) && (r_rep == '0) && !abort;
        case (w_state_nxt)
`ifdef SEQ_TX_PREAMBLE_EN
            c_PRE:   w_out_nxt = ~w_pre_nxt[0];
`endif
            c_DATA:  w_out_nxt = w_word_nxt[w_bit_nxt];
            default: w_out_nxt = 1'b0;
        endcase
    end

    assign out_seq = r_out;
    assign busy    = r_busy;
    assign ready   = ~r_busy;
    assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_seq_tx.sv
// tb_seq_tx: directed scoreboard bench for seq_tx (WIDTH=8, REP_W=4).
`default_nettype none

module tb_seq_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data_in = '0;
    logic [3:0] rep_in = '0;
    logic       abort = 1'b0;
    logic       out_seq, busy, ready, done;

    int n_checks = 0;
    int n_errors = 0;
    logic q[$];

`ifdef SEQ_TX_PREAMBLE_EN
    localparam int PRE_LEN = 3;
`else
    localparam int PRE_LEN = 0;
`endif

    seq_tx #(.WIDTH(8), .REP_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .rep_in  (rep_in),
        .abort   (abort),
        .out_seq (out_seq),
        .busy    (busy),
        .ready   (ready),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push_frames(input logic [7:0] d, input int reps);
        for (int f = 0; f <= reps; f++) begin
            if (PRE_LEN == 3) begin
                q.push_back(1'b1);
                q.push_back(1'b0);
                q.push_back(1'b1);
            end
            for (int i = 7; i >= 0; i--) q.push_back(d[i]);
            q.push_back(1'b0);
        end
    endtask

    task automatic step();
        logic e;
        @(posedge clk); #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("out_seq", out_seq, e);
            chk("busy_high", busy, 1'b1);
            chk("ready_low", ready, 1'b0);
            chk("done_low", done, 1'b0);
        end
    endtask

    task automatic start_tx(input logic [7:0] d, input logic [3:0] r);
        start = 1'b1;
        data_in = d;
        rep_in = r;
        push_frames(d, int'(r));
        step();
        start = 1'b0;
    endtask

    task automatic drain();
        while (q.size() > 0) step();
    endtask

    task automatic finish_tx();
        @(posedge clk); #1;
        chk("done_pulse", done, 1'b1);
        chk("done_out_zero", out_seq, 1'b0);
        chk("done_busy_low", busy, 1'b0);
        chk("done_ready_high", ready, 1'b1);
    endtask

    task automatic idle_step(input string tag);
        @(posedge clk); #1;
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_out"}, out_seq, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", out_seq, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        reset = 1'b1;
        idle_step("post_rst");

        // Single frame 0xA5
        start_tx(8'hA5, 4'd0);
        drain();
        finish_tx();
        idle_step("after_a5");

        // Three frames of 0x0F with an ignored mid-stream start and data change
        start_tx(8'h0F, 4'd2);
        repeat (5) step();
        start = 1'b1;
        data_in = 8'hFF;
        rep_in = 4'd7;
        repeat (3) step();
        start = 1'b0;
        drain();
        finish_tx();
        idle_step("after_0f");

        // Abort on the 4th data bit
        start_tx(8'hA5, 4'd0);
        repeat (PRE_LEN + 3) step();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        q.delete();
        chk("abort_out", out_seq, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", ready, 1'b1);
        chk("abort_done", done, 1'b0);
        for (int i = 0; i < 14; i++) idle_step("abort_quiet");

        // abort together with start while idle: nothing accepted
        start = 1'b1;
        abort = 1'b1;
        data_in = 8'hA5;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", busy, 1'b0);
        chk("abort_start_ready", ready, 1'b1);
        idle_step("abort_start");

        // Reset asserted mid-frame
        start_tx(8'hA5, 4'd0);
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("midrst_out", out_seq, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_done", done, 1'b0);
        q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 14; i++) idle_step("midrst_quiet");

        // Back-to-back: start held through the done cycle
        start = 1'b1;
        data_in = 8'hA5;
        rep_in = 4'd0;
        push_frames(8'hA5, 0);
        step();
        data_in = 8'h3C;
        drain();
        finish_tx();
        push_frames(8'h3C, 0);
        step();
        start = 1'b0;
        drain();
        finish_tx();
        idle_step("after_b2b");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
